// File: rtl/can_tx_buf_ser_if.sv
// CPU register and BSP transmit signals of the CAN transmit buffer.
// CAN_TX_SINGLE_SHOT_EN adds the single_shot control line.
interface can_tx_buf_ser_if;
  logic [3:0] c_addr;
  logic [7:0] c_din;
  logic       c_wrn;
  logic [7:0] c_dout;
  logic       tx_req;
  logic       tx_abort;
  logic       bit_req;
  logic       tx_ok;
  logic       restart;
`ifdef CAN_TX_SINGLE_SHOT_EN
  logic       single_shot;
`endif
  logic       tx_bit;
  logic       tx_valid;
  logic       tx_last;
  logic       tx_busy;
  logic       tx_done;
  logic       abort_done;

`ifdef CAN_TX_SINGLE_SHOT_EN
  modport master (
    output c_addr, c_din, c_wrn, tx_req, tx_abort, bit_req, tx_ok, restart, single_shot,
    input  c_dout, tx_bit, tx_valid, tx_last, tx_busy, tx_done, abort_done
  );
  modport slave (
    input  c_addr, c_din, c_wrn, tx_req, tx_abort, bit_req, tx_ok, restart, single_shot,
    output c_dout, tx_bit, tx_valid, tx_last, tx_busy, tx_done, abort_done
  );
`else
  modport master (
    output c_addr, c_din, c_wrn, tx_req, tx_abort, bit_req, tx_ok, restart,
    input  c_dout, tx_bit, tx_valid, tx_last, tx_busy, tx_done, abort_done
  );
  modport slave (
    input  c_addr, c_din, c_wrn, tx_req, tx_abort, bit_req, tx_ok, restart,
    output c_dout, tx_bit, tx_valid, tx_last, tx_busy, tx_done, abort_done
  );
`endif
endinterface

// File: rtl/can_tx_buf_ser.sv
// can_tx_buf_ser: 10-byte CAN transmit buffer serialised MSB-first to the BSP.
// Optional macro CAN_TX_SINGLE_SHOT_EN: single_shot turns restart into a drop with abort_done.
module can_tx_buf_ser #(
  parameter logic [7:0] RST_VAL  = 8'hff,
  parameter int         MAX_DATA = 8
) (
  input logic             clk,
  input logic             rsn,
  can_tx_buf_ser_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, SHIFT = 2'd2, WAIT = 2'd3} state_t;
  localparam logic [3:0] MAX_DLC = 4'(MAX_DATA);

  state_t     state_r, state_nxt_s;
  logic [7:0] buf_r [10];
  logic [7:0] shift_r;
  logic [2:0] bit_cnt_r;
  logic [3:0] byte_idx_r;
  logic [3:0] n_r;
  logic       busy_r, done_r, abort_done_r, abort_pend_r;

  logic       in_buf_s, wr_en_s, last_s, abort_s, drop_s;
  logic       load_s, adv_s, done_s, abort_pulse_s;
  logic [3:0] dlc_s, n_s, next_idx_s;

  assign in_buf_s   = (bus.c_addr <= 4'd9);
  assign wr_en_s    = !bus.c_wrn && in_buf_s && !busy_r;
  assign dlc_s      = buf_r[1][3:0];
  assign n_s        = buf_r[1][4] ? 4'd0 : ((dlc_s > MAX_DLC) ? MAX_DLC : dlc_s);
  assign next_idx_s = byte_idx_r + 4'd1;
  // Final bit: last bit of byte 1+n (the ID/control bytes precede the data).
  assign last_s     = (byte_idx_r == (n_r + 4'd1)) && (bit_cnt_r == 3'd7);
  assign abort_s    = abort_pend_r | bus.tx_abort;
`ifdef CAN_TX_SINGLE_SHOT_EN
  assign drop_s     = abort_s | bus.single_shot;
`else
  assign drop_s     = abort_s;
`endif

  // Next-state and event decode for the transmit sequencer.
  always_comb begin
    state_nxt_s   = state_r;
    load_s        = 1'b0;
    adv_s         = 1'b0;
    done_s        = 1'b0;
    abort_pulse_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.tx_req) state_nxt_s = LOAD;
        else            state_nxt_s = IDLE;
      end
      LOAD: begin
        load_s      = 1'b1;
        state_nxt_s = SHIFT;
      end
      SHIFT: begin
        if (bus.restart) begin
          if (drop_s) begin
            state_nxt_s   = IDLE;
            abort_pulse_s = 1'b1;
          end else begin
            state_nxt_s = LOAD;
          end
        end else if (bus.bit_req) begin
          if (last_s) state_nxt_s = WAIT;
          else        adv_s       = 1'b1;
        end else begin
          state_nxt_s = SHIFT;
        end
      end
      WAIT: begin
        if (bus.tx_ok) begin
          state_nxt_s = IDLE;
          done_s      = 1'b1;
        end else if (bus.restart) begin
          if (drop_s) begin
            state_nxt_s   = IDLE;
            abort_pulse_s = 1'b1;
          end else begin
            state_nxt_s = LOAD;
          end
        end else begin
          state_nxt_s = WAIT;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Sequencer state, lock flag, pending abort and completion pulses.
  always_ff @(posedge clk or negedge rsn) begin
    if (!rsn) begin
      state_r      <= IDLE;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      abort_done_r <= 1'b0;
      abort_pend_r <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      busy_r       <= (state_nxt_s != IDLE);
      done_r       <= done_s;
      abort_done_r <= abort_pulse_s;
      abort_pend_r <= (state_nxt_s == IDLE) ? 1'b0
                    : (abort_pend_r | ((state_r != IDLE) & bus.tx_abort));
    end
  end

  // CPU-writable frame buffer, locked while a frame is pending.
  always_ff @(posedge clk or negedge rsn) begin
    if (!rsn) begin
      for (int i = 0; i < 10; i++) buf_r[i] <= RST_VAL;
    end else if (wr_en_s) begin
      buf_r[bus.c_addr] <= bus.c_din;
    end
  end

  // Shift register with bit/byte position; next byte is fetched on the 8th bit_req.
  always_ff @(posedge clk or negedge rsn) begin
    if (!rsn) begin
      shift_r    <= 8'h00;
      bit_cnt_r  <= 3'd0;
      byte_idx_r <= 4'd0;
      n_r        <= 4'd0;
    end else if (load_s) begin
      shift_r    <= buf_r[0];
      bit_cnt_r  <= 3'd0;
      byte_idx_r <= 4'd0;
      n_r        <= n_s;
    end else if (adv_s) begin
      if (bit_cnt_r == 3'd7) begin
        shift_r    <= buf_r[next_idx_s];
        bit_cnt_r  <= 3'd0;
        byte_idx_r <= next_idx_s;
      end else begin
        shift_r   <= {shift_r[6:0], 1'b0};
        bit_cnt_r <= bit_cnt_r + 3'd1;
      end
    end
  end

  assign bus.c_dout     = in_buf_s ? buf_r[bus.c_addr] : 8'h00;
  assign bus.tx_valid   = (state_r == SHIFT);
  assign bus.tx_bit     = (state_r == SHIFT) & shift_r[7];
  assign bus.tx_last    = (state_r == SHIFT) & last_s;
  assign bus.tx_busy    = busy_r;
  assign bus.tx_done    = done_r;
  assign bus.abort_done = abort_done_r;
endmodule

// File: tb/tb_can_tx_buf_ser.sv
// Self-checking bench for can_tx_buf_ser: expected bit stream queued from a buffer model.
module tb_can_tx_buf_ser;
  logic clk = 1'b0;
  logic rsn;
  always #5 clk = ~clk;

  can_tx_buf_ser_if bus();
  can_tx_buf_ser dut (.clk(clk), .rsn(rsn), .bus(bus));

  int checks   = 0;
  int failures = 0;
  logic [7:0] mem_m [10];
  logic [1:0] exp_q [$];  // {last, bit}

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 10; i++) mem_m[i] = 8'hff;
  endtask

  task automatic cpu_write(input logic [3:0] addr, input logic [7:0] data);
    bus.c_addr = addr;
    bus.c_din  = data;
    bus.c_wrn  = 1'b0;
    cycle();
    bus.c_wrn  = 1'b1;
    if (addr < 4'd10) mem_m[addr] = data;
  endtask

  task automatic push_frame();
    int n;
    n = mem_m[1][4] ? 0 : ((mem_m[1][3:0] > 4'd8) ? 8 : int'(mem_m[1][3:0]));
    for (int b = 0; b < 2 + n; b++)
      for (int k = 7; k >= 0; k--)
        exp_q.push_back({(b == 1 + n) && (k == 0), mem_m[b][k]});
  endtask

  task automatic start_frame();
    push_frame();
    bus.tx_req = 1'b1;
    cycle();
    bus.tx_req = 1'b0;
    cycle();
  endtask

  // BSP model: take one bit every three cycles and score it against the queue.
  task automatic consume(input int nbits);
    int wait_c;
    logic [1:0] e;
    for (int i = 0; i < nbits; i++) begin
      wait_c = 0;
      while (bus.tx_valid !== 1'b1 && wait_c < 20) begin
        cycle();
        wait_c++;
      end
      checks++;
      if (bus.tx_valid !== 1'b1) begin
        failures++;
        $display("FAIL bit_timeout bit=%0d tx_valid=%b required 1", i, bus.tx_valid);
        return;
      end
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL scoreboard_empty bit=%0d", i);
        return;
      end
      e = exp_q.pop_front();
      if ({bus.tx_last, bus.tx_bit} !== e) begin
        failures++;
        $display("FAIL tx_bit bit=%0d got last/bit=%b required %b", i, {bus.tx_last, bus.tx_bit}, e);
      end
      bus.bit_req = 1'b1;
      cycle();
      bus.bit_req = 1'b0;
      cycle();
      cycle();
    end
  endtask

  task automatic test_reset();
    rsn = 1'b0;
    model_reset();
    repeat (3) cycle();
    rsn = 1'b1;
    cycle();
    bus.c_addr = 4'd0;
    #1;
    checks++;
    if ({bus.tx_bit, bus.tx_valid, bus.tx_last, bus.tx_busy, bus.tx_done, bus.abort_done} !== 6'b0) begin
      failures++;
      $display("FAIL reset_outputs got=%b required 000000",
               {bus.tx_bit, bus.tx_valid, bus.tx_last, bus.tx_busy, bus.tx_done, bus.abort_done});
    end
    checks++;
    if (bus.c_dout !== 8'hff) begin failures++; $display("FAIL reset_byte0 got=%h required ff", bus.c_dout); end
    bus.c_addr = 4'd9;
    #1;
    checks++;
    if (bus.c_dout !== 8'hff) begin failures++; $display("FAIL reset_byte9 got=%h required ff", bus.c_dout); end
  endtask

  task automatic test_basic();
    cpu_write(4'd0, 8'h24);
    cpu_write(4'd1, 8'h62);
    cpu_write(4'd2, 8'hA5);
    cpu_write(4'd3, 8'h3C);
    bus.c_addr = 4'd1;
    #1;
    checks++;
    if (bus.c_dout !== 8'h62) begin failures++; $display("FAIL readback_b1 got=%h required 62", bus.c_dout); end
    push_frame();
    bus.tx_req = 1'b1;
    cycle();
    bus.tx_req = 1'b0;
    checks++;
    if ({bus.tx_busy, bus.tx_valid} !== 2'b10) begin
      failures++; $display("FAIL load_cycle busy/valid got=%b required 10", {bus.tx_busy, bus.tx_valid});
    end
    cycle();
    consume(32);
    checks++;
    if (exp_q.size() != 0 || {bus.tx_busy, bus.tx_valid} !== 2'b10) begin
      failures++; $display("FAIL basic_wait left=%0d busy/valid got=%b required 10", exp_q.size(), {bus.tx_busy, bus.tx_valid});
    end
    bus.tx_ok = 1'b1;
    cycle();
    bus.tx_ok = 1'b0;
    checks++;
    if ({bus.tx_done, bus.tx_busy} !== 2'b10) begin
      failures++; $display("FAIL basic_done done/busy got=%b required 10", {bus.tx_done, bus.tx_busy});
    end
    cycle();
    checks++;
    if (bus.tx_done !== 1'b0) begin failures++; $display("FAIL done_pulse_width got=%b required 0", bus.tx_done); end
  endtask

  task automatic test_length();
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 0) begin
        cpu_write(4'd1, 8'h7F);
      end else begin
        cpu_write(4'd1, 8'h0F);
        for (int a = 2; a < 10; a++) cpu_write(4'(a), 8'($urandom_range(0, 255)));
      end
      start_frame();
      consume(pass == 0 ? 16 : 80);
      checks++;
      if (exp_q.size() != 0 || bus.tx_valid !== 1'b0) begin
        failures++; $display("FAIL length_end pass=%0d left=%0d tx_valid=%b required 0", pass, exp_q.size(), bus.tx_valid);
      end
      bus.tx_ok = 1'b1;
      cycle();
      bus.tx_ok = 1'b0;
      checks++;
      if ({bus.tx_done, bus.tx_busy} !== 2'b10) begin
        failures++; $display("FAIL length_done pass=%0d got=%b required 10", pass, {bus.tx_done, bus.tx_busy});
      end
    end
    cpu_write(4'd1, 8'h62);
    cpu_write(4'd2, 8'hA5);
    cpu_write(4'd3, 8'h3C);
  endtask

  task automatic test_restart();
    int done_cnt;
    start_frame();
    consume(7);
    bus.restart = 1'b1;
    cycle();
    bus.restart = 1'b0;
    checks++;
    if ({bus.tx_busy, bus.tx_valid} !== 2'b10) begin
      failures++; $display("FAIL restart_load busy/valid got=%b required 10", {bus.tx_busy, bus.tx_valid});
    end
    exp_q.delete();
    push_frame();
    cycle();
    consume(32);
    bus.tx_ok = 1'b1;
    cycle();
    bus.tx_ok = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      if (bus.tx_done === 1'b1) done_cnt++;
      cycle();
    end
    checks++;
    if (done_cnt != 1 || exp_q.size() != 0) begin
      failures++; $display("FAIL restart_single_done got=%0d required 1 (left=%0d)", done_cnt, exp_q.size());
    end
  endtask

  task automatic test_abort();
    logic seen;
    start_frame();
    consume(5);
    bus.tx_abort = 1'b1;
    cycle();
    bus.tx_abort = 1'b0;
    checks++;
    if ({bus.tx_busy, bus.tx_valid, bus.abort_done} !== 3'b110) begin
      failures++; $display("FAIL abort_pending got=%b required 110", {bus.tx_busy, bus.tx_valid, bus.abort_done});
    end
    bus.restart = 1'b1;
    cycle();
    bus.restart = 1'b0;
    checks++;
    if ({bus.abort_done, bus.tx_busy, bus.tx_valid} !== 3'b100) begin
      failures++; $display("FAIL abort_restart got=%b required 100", {bus.abort_done, bus.tx_busy, bus.tx_valid});
    end
    exp_q.delete();
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      seen = seen | bus.tx_valid | bus.tx_busy | bus.abort_done;
    end
    checks++;
    if (seen !== 1'b0) begin failures++; $display("FAIL abort_no_retx got=%b required 0", seen); end
    // abort followed by a successful frame reports tx_done only
    start_frame();
    bus.tx_abort = 1'b1;
    cycle();
    bus.tx_abort = 1'b0;
    consume(32);
    bus.tx_ok = 1'b1;
    cycle();
    bus.tx_ok = 1'b0;
    checks++;
    if ({bus.tx_done, bus.abort_done, bus.tx_busy} !== 3'b100) begin
      failures++; $display("FAIL abort_then_ok got=%b required 100", {bus.tx_done, bus.abort_done, bus.tx_busy});
    end
    // abort_pend must not leak into the next frame
    start_frame();
    consume(3);
    bus.restart = 1'b1;
    cycle();
    bus.restart = 1'b0;
    checks++;
    if ({bus.tx_busy, bus.abort_done} !== 2'b10) begin
      failures++; $display("FAIL abort_cleared got=%b required 10", {bus.tx_busy, bus.abort_done});
    end
    exp_q.delete();
    push_frame();
    consume(32);
    bus.tx_ok = 1'b1;
    cycle();
    bus.tx_ok = 1'b0;
    checks++;
    if (bus.tx_done !== 1'b1) begin failures++; $display("FAIL abort_cleared_done got=%b required 1", bus.tx_done); end
  endtask

  task automatic test_writes();
    start_frame();
    bus.c_addr = 4'd2;
    bus.c_din  = 8'h55;
    bus.c_wrn  = 1'b0;
    cycle();
    bus.c_wrn  = 1'b1;
    #1;
    checks++;
    if (bus.c_dout !== mem_m[2]) begin failures++; $display("FAIL write_busy got=%h required %h", bus.c_dout, mem_m[2]); end
    bus.c_addr = 4'd12;
    #1;
    checks++;
    if (bus.c_dout !== 8'h00) begin failures++; $display("FAIL read_addr12 got=%h required 00", bus.c_dout); end
    consume(32);
    bus.tx_ok = 1'b1;
    cycle();
    bus.tx_ok = 1'b0;
    checks++;
    if (bus.tx_done !== 1'b1) begin failures++; $display("FAIL busy_frame_done got=%b required 1", bus.tx_done); end
    // write and tx_req together: the frame carries the new byte
    bus.c_addr = 4'd3;
    bus.c_din  = 8'h99;
    bus.c_wrn  = 1'b0;
    bus.tx_req = 1'b1;
    mem_m[3]   = 8'h99;
    cycle();
    bus.c_wrn  = 1'b1;
    bus.tx_req = 1'b0;
    push_frame();
    cycle();
    consume(32);
    bus.tx_ok = 1'b1;
    cycle();
    bus.tx_ok = 1'b0;
    checks++;
    if (exp_q.size() != 0 || bus.tx_done !== 1'b1) begin
      failures++; $display("FAIL req_with_write left=%0d done=%b required 1", exp_q.size(), bus.tx_done);
    end
  endtask

  task automatic test_async_reset();
    logic seen;
    start_frame();
    consume(10);
    bus.c_addr = 4'd0;
    #2;
    rsn = 1'b0;
    #1;
    checks++;
    if ({bus.tx_bit, bus.tx_valid, bus.tx_last, bus.tx_busy, bus.tx_done, bus.abort_done} !== 6'b0 ||
        bus.c_dout !== 8'hff) begin
      failures++;
      $display("FAIL async_reset outs=%b byte0=%h required 000000/ff",
               {bus.tx_bit, bus.tx_valid, bus.tx_last, bus.tx_busy, bus.tx_done, bus.abort_done}, bus.c_dout);
    end
    model_reset();
    exp_q.delete();
    @(negedge clk);
    rsn = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      seen = seen | bus.tx_done | bus.abort_done | bus.tx_busy;
    end
    checks++;
    if (seen !== 1'b0) begin failures++; $display("FAIL async_reset_quiet got=%b required 0", seen); end
  endtask

`ifdef CAN_TX_SINGLE_SHOT_EN
  task automatic test_single_shot();
    bus.single_shot = 1'b1;
    start_frame();
    consume(4);
    bus.restart = 1'b1;
    cycle();
    bus.restart = 1'b0;
    checks++;
    if ({bus.abort_done, bus.tx_busy} !== 2'b10) begin
      failures++; $display("FAIL single_shot got=%b required 10", {bus.abort_done, bus.tx_busy});
    end
    cycle();
    checks++;
    if (bus.tx_valid !== 1'b0) begin failures++; $display("FAIL single_shot_no_retx got=%b required 0", bus.tx_valid); end
    exp_q.delete();
    bus.single_shot = 1'b0;
  endtask
`endif

  initial begin
    bus.c_addr   = 4'd0;
    bus.c_din    = 8'h00;
    bus.c_wrn    = 1'b1;
    bus.tx_req   = 1'b0;
    bus.tx_abort = 1'b0;
    bus.bit_req  = 1'b0;
    bus.tx_ok    = 1'b0;
    bus.restart  = 1'b0;
`ifdef CAN_TX_SINGLE_SHOT_EN
    bus.single_shot = 1'b0;
`endif
    test_reset();
    test_basic();
    test_length();
    test_restart();
    test_abort();
    test_writes();
    test_async_reset();
`ifdef CAN_TX_SINGLE_SHOT_EN
    test_single_shot();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/can_tx_buf_ser.md
Name: can_tx_buf_ser

Overview:
- Transmit-side buffer for the Basic CAN controller: CPU writes a 10-byte frame descriptor, issues a transmit request, and the block serialises it MSB-first to the bit-stream processor (BSP) on demand.
- Buffer layout: byte 0 = ID[10:3]; byte 1 = {ID[2:0], RTR, DLC[3:0]}; bytes 2..9 = data.
- Handles retransmission after arbitration loss or error, and abort. Sits between the CPU register interface and the BSP transmit path.

Parameters:
- RST_VAL, 8'hff, reset value of every buffer byte.
- MAX_DATA, 8, maximum data bytes sent; the effective DLC is clamped to this.

Ports:
- clk  input  1  clock
- rsn  input  1  reset, asynchronous, active low
- c_addr  input  4  CPU buffer address
- c_din  input  8  CPU write data
- c_wrn  input  1  CPU write strobe, active low
- c_dout  output  8  CPU read data (combinational)
- tx_req  input  1  transmit request pulse
- tx_abort  input  1  abort request pulse
- bit_req  input  1  BSP consumed the current bit; advance
- tx_ok  input  1  BSP frame completed successfully
- restart  input  1  BSP arbitration lost or error; rewind
- tx_bit  output  1  current bit to transmit
- tx_valid  output  1  tx_bit is valid
- tx_last  output  1  tx_bit is the final bit of the frame
- tx_busy  output  1  buffer locked, transmission pending or in progress
- tx_done  output  1  one-cycle pulse, frame sent
- abort_done  output  1  one-cycle pulse, transmission aborted

Behaviour:
- Reset: all bytes = RST_VAL; state = IDLE; tx_bit = 0; tx_valid, tx_last, tx_busy, tx_done, abort_done = 0.
- Writes: when c_wrn = 0, c_addr 0..9 and tx_busy = 0, the byte is written on the next clk edge. Writes while busy, and writes to addresses 10..15, are ignored.
- c_dout returns the addressed byte for 0..9 and 8'h00 for 10..15. Reads are always allowed.
- Frame length: n = 0 if RTR = 1, else min(DLC, MAX_DATA). Total bits = 16 + 8n, with byte 0 first, each byte MSB first. The BSP inserts IDE/r0 by withholding bit_req.
- FSM states: IDLE, LOAD, SHIFT, WAIT.
  - IDLE: tx_req → LOAD and tx_busy = 1 on the same edge.
  - LOAD (1 cycle): latch n, load byte 0 into the shift register, bit count = 0 → SHIFT.
  - SHIFT: tx_valid = 1; tx_bit = shift[7].
    - Each bit_req shifts left by one.
    - After the 8th bit_req of a byte, the next byte is loaded on the same edge.
    - tx_last = 1 while the final bit is presented.
    - bit_req on the final bit → WAIT.
  - WAIT: tx_valid = 0.
    - tx_ok → IDLE, tx_done pulse, tx_busy = 0.
    - restart → LOAD.
- restart in SHIFT rewinds to LOAD. The frame restarts from ID[10] two cycles later.
- Abort:
  - In IDLE, tx_abort is ignored.
  - In LOAD, SHIFT or WAIT it sets abort_pend.
  - restart with abort_pend → IDLE plus abort_done pulse, no retransmit.
  - tx_ok with abort_pend → normal tx_done; abort_pend is cleared.
- Simultaneous events:
  - tx_ok and restart together: tx_ok wins.
  - bit_req outside SHIFT is ignored.
  - tx_req while busy is ignored.
  - tx_req and a buffer write in the same cycle: the write is accepted and the frame uses the new value.
- Asynchronous reset mid-frame returns everything to reset values immediately. No pulse is generated.

Optional Feature:
- CAN_TX_SINGLE_SHOT_EN. When defined, adds input single_shot (1 bit).
  - While single_shot = 1, restart in SHIFT/WAIT → IDLE, tx_busy = 0, abort_done pulse; no retransmit.
  - When not defined, the port is absent and restart always retransmits.

Test Plan:
- Write ID = 0x123 (byte0 = 0x24, byte1 = 0x62: RTR = 0, DLC = 2), data 0xA5, 0x3C; tx_req; bit_req every 3 cycles → 32 bits = 0x2462A53C MSB first; tx_last on bit 32; tx_ok → tx_done, tx_busy = 0.
- byte1 = 0x7F (RTR = 1, DLC = 15) → exactly 16 bits; DLC = 15 with RTR = 0 → 80 bits (clamped to 8 data bytes).
- restart after 7 bits → tx_valid drops for the LOAD cycle, then re-sends from byte0 bit7; full frame then tx_ok → single tx_done.
- tx_abort mid-SHIFT then restart → abort_done, tx_busy = 0, no retransmit. tx_abort then tx_ok → tx_done only.
- Write 0x55 to address 2 while busy → readback unchanged; address 12 reads 0x00; rsn low mid-frame → all outputs 0, bytes = 0xFF.
- Single-shot (with CAN_TX_SINGLE_SHOT_EN) with single_shot = 1: restart → abort_done, no retransmit.
